// File: rtl/ibex_register_file_wipe.sv
`default_nettype none
// ============================================================================
// Module   : ibex_register_file_wipe
// Brief    : Flip-flop register file with hard-wired word 0 and a sequential
//            wipe engine that resets every architectural register to WipeVal.
// Revision : 1.0
// ============================================================================
module ibex_register_file_wipe #(
  parameter int unsigned          DataWidth    = 32,
  parameter int unsigned          NumWords     = 32,
  parameter int unsigned          NumRead      = 2,
  parameter int unsigned          WipePerCycle = 1,
  parameter logic [DataWidth-1:0] WipeVal      = '0
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NumRead*5-1:0]           raddr_i,
  output logic [NumRead*DataWidth-1:0]   rdata_o,
  input  logic [4:0]                     waddr_i,
  input  logic [DataWidth-1:0]           wdata_i,
  input  logic                           we_i,
  input  logic                           sec_zero_i,
  input  logic                           wipe_req_i,
  output logic                           wipe_busy_o,
  output logic                           wipe_done_o,
  output logic                           err_o
);

  localparam int unsigned          c_cnt_w = $clog2(NumWords) + 1;
  localparam logic [c_cnt_w-1:0]   c_step  = c_cnt_w'(WipePerCycle);
  localparam logic [c_cnt_w-1:0]   c_words = c_cnt_w'(NumWords);
  localparam logic [c_cnt_w-1:0]   c_one   = c_cnt_w'(1);
  localparam logic [5:0]           c_nw6   = 6'(NumWords);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWipe = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e               r_state;
  logic [c_cnt_w-1:0]   r_cnt;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_err;
  logic [DataWidth-1:0] r_mem [1:NumWords-1];

  logic [c_cnt_w-1:0]   w_cnt_end;
  logic                 w_last;
  logic                 w_wiping;
  logic                 w_waddr_oob;
  logic                 w_we_ok;
  logic                 w_err;
  logic [DataWidth-1:0] w_wdata;
  logic [DataWidth-1:0] w_rf [32];

  // The wipe window covers [r_cnt, w_cnt_end); indices past NumWords-1 simply do not exist.
  assign w_cnt_end   = r_cnt + c_step;
  assign w_last      = (w_cnt_end >= c_words);
  assign w_wiping    = (r_state == StWipe);
  assign w_waddr_oob = ({1'b0, waddr_i} >= c_nw6);
  assign w_we_ok     = we_i && !w_wiping && (waddr_i != 5'd0) && !w_waddr_oob;
  assign w_err       = we_i && (w_wiping || w_waddr_oob);
  assign w_wdata     = sec_zero_i ? WipeVal : wdata_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 1; i < int'(NumWords); i++) begin
        r_mem[i] <= WipeVal;
      end
    end else begin
      for (int i = 1; i < int'(NumWords); i++) begin
        if (w_wiping && (c_cnt_w'(i) >= r_cnt) && (c_cnt_w'(i) < w_cnt_end)) begin
          r_mem[i] <= WipeVal;
        end else if (w_we_ok && (waddr_i == 5'(i))) begin
          r_mem[i] <= w_wdata;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= StIdle;
      r_cnt   <= c_one;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err  <= w_err;
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (wipe_req_i) begin
            r_state <= StWipe;
            r_busy  <= 1'b1;
            r_cnt   <= c_one;
          end
        end
        StWipe: begin
          if (w_last) begin
            r_state <= StDone;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_cnt   <= c_one;
          end else begin
            r_cnt <= w_cnt_end;
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_cnt   <= c_one;
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
          r_cnt   <= c_one;
        end
      endcase
    end
  end

  // Full 32-entry view so any 5-bit address resolves; unimplemented words read WipeVal.
  generate
    for (genvar i = 0; i < 32; i++) begin : g_rf
      if ((i == 0) || (i >= int'(NumWords))) begin : g_const
        assign w_rf[i] = WipeVal;
      end else begin : g_reg
        assign w_rf[i] = r_mem[i];
      end
    end
    for (genvar k = 0; k < int'(NumRead); k++) begin : g_rd
      assign rdata_o[k*DataWidth +: DataWidth] = w_rf[raddr_i[k*5 +: 5]];
    end
  endgenerate

  assign wipe_busy_o = r_busy;
  assign wipe_done_o = r_done;
  assign err_o       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ibex_register_file_wipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_ibex_register_file_wipe
// Brief    : Self-checking bench; two instances (32 words/1 per cycle and
//            16 words/4 per cycle) share stimulus and a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_ibex_register_file_wipe;

  logic        clk;
  logic        rst;
  logic [9:0]  raddr;
  logic [63:0] rdata_a, rdata_b;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        we, sz, req;
  logic        busy_a, done_a, err_a, busy_b, done_b, err_b;

  int n_checks = 0;
  int n_fail   = 0;

  ibex_register_file_wipe #(.DataWidth(32), .NumWords(32), .NumRead(2), .WipePerCycle(1), .WipeVal('0)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .raddr_i(raddr), .rdata_o(rdata_a), .waddr_i(waddr), .wdata_i(wdata),
    .we_i(we), .sec_zero_i(sz), .wipe_req_i(req), .wipe_busy_o(busy_a), .wipe_done_o(done_a), .err_o(err_a)
  );

  ibex_register_file_wipe #(.DataWidth(32), .NumWords(16), .NumRead(2), .WipePerCycle(4), .WipeVal('0)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .raddr_i(raddr), .rdata_o(rdata_b), .waddr_i(waddr), .wdata_i(wdata),
    .we_i(we), .sec_zero_i(sz), .wipe_req_i(req), .wipe_busy_o(busy_b), .wipe_done_o(done_b), .err_o(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: per instance, the register contents, the next index still to be wiped
  // (0 = not wiping), and the done / err flags as seen after each edge.
  int          c_nw  [2] = '{32, 16};
  int          c_wpc [2] = '{1, 4};
  logic [31:0] m_reg [2][32];
  int          m_next[2];
  bit          m_done[2];
  bit          m_err [2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < 32; r++) m_reg[d][r] = '0;
      m_next[d] = 0;
      m_done[d] = 0;
      m_err[d]  = 0;
    end
  endtask

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      bit wiping   = (m_next[d] != 0);
      bit was_done = m_done[d];
      m_err[d] = we && (wiping || (int'(waddr) >= c_nw[d]));
      if (!wiping && we && waddr != 0 && int'(waddr) < c_nw[d])
        m_reg[d][waddr] = sz ? 32'h0 : wdata;
      if (wiping) begin
        for (int j = 0; j < c_wpc[d]; j++)
          if (m_next[d] + j < c_nw[d]) m_reg[d][m_next[d] + j] = '0;
        m_next[d] += c_wpc[d];
        m_done[d] = 0;
        if (m_next[d] >= c_nw[d]) begin
          m_next[d] = 0;
          m_done[d] = 1;
        end
      end else begin
        m_done[d] = 0;
        if (!was_done && req) m_next[d] = 1;
      end
    end
  endtask

  function automatic logic [31:0] mread(int d, logic [4:0] a);
    return (a == 0 || int'(a) >= c_nw[d]) ? 32'h0 : m_reg[d][a];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outputs();
    chk("busy_a", {31'b0, busy_a}, {31'b0, m_next[0] != 0});
    chk("done_a", {31'b0, done_a}, {31'b0, m_done[0]});
    chk("err_a",  {31'b0, err_a},  {31'b0, m_err[0]});
    chk("busy_b", {31'b0, busy_b}, {31'b0, m_next[1] != 0});
    chk("done_b", {31'b0, done_b}, {31'b0, m_done[1]});
    chk("err_b",  {31'b0, err_b},  {31'b0, m_err[1]});
  endtask

  task automatic check_reads();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 2; k++) begin
        logic [4:0]  a   = raddr[k*5 +: 5];
        logic [31:0] act = (d == 0) ? rdata_a[k*32 +: 32] : rdata_b[k*32 +: 32];
        chk($sformatf("rdata d%0d p%0d x%0d", d, k, a), act, mread(d, a));
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_reset(); else model_edge();
    #1;
    check_outputs();
    check_reads();
  endtask

  task automatic sweep_reads();
    for (int a = 0; a < 32; a++) begin
      raddr = {5'(31 - a), 5'(a)};
      #1;
      check_reads();
    end
  endtask

  task automatic fill();
    for (int i = 1; i < 32; i++) begin
      we = 1; waddr = 5'(i); wdata = i; sz = 0;
      cycle();
    end
    we = 0;
  endtask

  // Runs a wipe from IDLE and counts busy cycles / done pulses on both instances.
  task automatic run_wipe(input bit poke);
    int busy_cnt_a = 0, busy_cnt_b = 0, done_cnt_a = 0, done_cnt_b = 0;
    req = 1;
    cycle();
    req = 0;
    busy_cnt_a += busy_a; busy_cnt_b += busy_b;
    for (int i = 1; i <= 45; i++) begin
      cycle();
      busy_cnt_a += busy_a; busy_cnt_b += busy_b;
      done_cnt_a += done_a; done_cnt_b += done_b;
      if (poke && i == 5) begin
        we = 1; waddr = 5'd3; wdata = 32'h33;
      end
      if (poke && i == 6) begin
        chk("err_on_write_during_wipe", {31'b0, err_a}, 32'd1);
        we = 0;
      end
      if (poke && i == 10) begin
        raddr = {5'd11, 5'd10};
        #1;
        chk("mid_wipe_x10_cleared", rdata_a[31:0], 32'd0);
        chk("mid_wipe_x11_kept", rdata_a[63:32], 32'd11);
      end
    end
    chk("busy_cycles_a", busy_cnt_a, 32'd31);
    chk("busy_cycles_b", busy_cnt_b, 32'd4);
    chk("done_pulses_a", done_cnt_a, 32'd1);
    chk("done_pulses_b", done_cnt_b, 32'd1);
    raddr = {5'd15, 5'd3};
    #1;
    chk("x3_after_wipe_a", rdata_a[31:0], 32'd0);
    sweep_reads();
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        sz;
    logic [4:0]  ra;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic        err_a;
    logic        err_b;
  } vec_t;

  vec_t tbl [9];

  initial begin
    tbl[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 5'd6,  32'h12345678, 1'b1, 5'd6,  32'h0,        32'h0,        1'b0, 1'b0};
    tbl[2] = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 5'd0,  32'h0,        32'h0,        1'b0, 1'b0};
    tbl[3] = '{1'b1, 5'd7,  32'hA5A5A5A5, 1'b0, 5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd7,  32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 5'd7,  32'h11111111, 1'b1, 5'd7,  32'h0,        32'h0,        1'b0, 1'b0};
    tbl[6] = '{1'b1, 5'd31, 32'hCAFEF00D, 1'b0, 5'd31, 32'hCAFEF00D, 32'h0,        1'b0, 1'b1};
    tbl[7] = '{1'b1, 5'd20, 32'h00000077, 1'b0, 5'd20, 32'h00000077, 32'h0,        1'b0, 1'b1};
    tbl[8] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd31, 32'hCAFEF00D, 32'h0,        1'b0, 1'b0};

    rst = 1; raddr = '0; waddr = '0; wdata = '0; we = 0; sz = 0; req = 0;
    model_reset();
    cycle();
    cycle();
    rst = 0;
    sweep_reads();

    // Directed vectors; the first row also checks the pre-edge (old) read value.
    for (int v = 0; v < 9; v++) begin
      we = tbl[v].we; waddr = tbl[v].waddr; wdata = tbl[v].wdata; sz = tbl[v].sz;
      raddr = {5'd0, tbl[v].ra};
      if (v == 0) begin
        #1;
        chk("read_old_in_write_cycle", rdata_a[31:0], 32'h0);
      end
      cycle();
      chk($sformatf("vec%0d rdata_a", v), rdata_a[31:0], tbl[v].exp_a);
      chk($sformatf("vec%0d rdata_b", v), rdata_b[31:0], tbl[v].exp_b);
      chk($sformatf("vec%0d err_a", v), {31'b0, err_a}, {31'b0, tbl[v].err_a});
      chk($sformatf("vec%0d err_b", v), {31'b0, err_b}, {31'b0, tbl[v].err_b});
    end
    we = 0;

    // Asynchronous reset between edges clears registers immediately.
    #2;
    rst = 1;
    model_reset();
    raddr = {5'd31, 5'd5};
    #1;
    chk("async_rst_x5", rdata_a[31:0], 32'h0);
    check_reads();
    check_outputs();
    cycle();
    rst = 0;

    fill();
    run_wipe(1'b1);

    // Reset in the tenth wipe cycle aborts without a done pulse.
    fill();
    req = 1;
    cycle();
    req = 0;
    for (int i = 1; i <= 9; i++) cycle();
    #2;
    rst = 1;
    model_reset();
    #1;
    chk("busy_drops_on_rst", {31'b0, busy_a}, 32'd0);
    check_outputs();
    raddr = {5'd31, 5'd20};
    #1;
    check_reads();
    cycle();
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("no_done_after_rst", {31'b0, done_a}, 32'd0);
    end
    sweep_reads();
    fill();
    run_wipe(1'b0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      we    = ($urandom % 2) == 0;
      waddr = 5'($urandom);
      wdata = $urandom;
      sz    = ($urandom % 4) == 0;
      req   = ($urandom % 16) == 0;
      raddr = 10'($urandom);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
